// File: rtl/ahb_slave_share_arbiter_if.sv
// Signal bundle joining two request/acknowledge requesters and one AHB-Lite slave port
// to the share arbiter. "master" is the arbiter's view, "slave" is the environment's view.
interface ahb_slave_share_arbiter_if #(
    parameter int AWIDTH = 10
);
    logic              REQ0;
    logic              REQ1;
    logic              WR0;
    logic              WR1;
    logic [AWIDTH-1:0] ADDR0;
    logic [AWIDTH-1:0] ADDR1;
    logic [31:0]       WDATA0;
    logic [31:0]       WDATA1;
    logic [2:0]        SIZE0;
    logic [2:0]        SIZE1;
    logic              ACK0;
    logic              ACK1;
    logic [31:0]       RDATA;
    logic              ERR;
    logic              TOUT;

    logic              HSEL;
    logic              HWRITE;
    logic [AWIDTH-1:0] HADDR;
    logic [31:0]       HWDATA;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic              HMASTLOCK;
    logic [3:0]        HPROT;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        input  REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, SIZE0, SIZE1,
        output ACK0, ACK1, RDATA, ERR, TOUT,
        output HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        output REQ0, REQ1, WR0, WR1, ADDR0, ADDR1, WDATA0, WDATA1, SIZE0, SIZE1,
        input  ACK0, ACK1, RDATA, ERR, TOUT,
        input  HSEL, HWRITE, HADDR, HWDATA, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_share_arbiter.sv
// Round-robin sharing of one AHB-Lite slave port between two requesters; one single
// NONSEQ transfer per grant with a data-phase timeout guarding against a hung slave.
module ahb_slave_share_arbiter #(
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic                     i_hclk,
    input  logic                     i_hreset,
    ahb_slave_share_arbiter_if.master bus
);
    // state | meaning
    // IDLE  | sample REQ0/REQ1, latch the round-robin winner's request
    // ADDR  | one NONSEQ address-phase cycle on the slave port
    // DATA  | data phase: wait for HREADYOUT or the wait-state limit
    // DONE  | one-cycle ACK to the winner, RDATA/ERR/TOUT valid
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    localparam int         CW            = $clog2(TIMEOUT + 2);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t        r_state;
    logic          r_last_gnt;
    logic          r_win;
    logic          r_wr;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_wait_left;

    logic w_any_req;
    logic w_pick1;
    logic w_timeout;

    assign w_any_req = bus.REQ0 | bus.REQ1;
    // On a tie the requester not granted last wins; a lone request always wins.
    assign w_pick1   = bus.REQ1 & (~bus.REQ0 | ~r_last_gnt);
    // Down-counter hits zero after TIMEOUT wait states; one more wait edge aborts.
    assign w_timeout = (TIMEOUT != 0) && (r_wait_left == '0);

    assign bus.HBURST    = 3'b000;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HPROT     = 4'b0011;

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state     <= IDLE;
            r_last_gnt  <= 1'b1;
            r_win       <= 1'b0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_wait_left <= '0;
            bus.ACK0    <= 1'b0;
            bus.ACK1    <= 1'b0;
            bus.RDATA   <= '0;
            bus.ERR     <= 1'b0;
            bus.TOUT    <= 1'b0;
            bus.HSEL    <= 1'b0;
            bus.HWRITE  <= 1'b0;
            bus.HADDR   <= '0;
            bus.HWDATA  <= '0;
            bus.HTRANS  <= HTRANS_IDLE;
            bus.HSIZE   <= 3'b010;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_win      <= w_pick1;
                        r_wr       <= w_pick1 ? bus.WR1    : bus.WR0;
                        r_wdata    <= w_pick1 ? bus.WDATA1 : bus.WDATA0;
                        bus.HWRITE <= w_pick1 ? bus.WR1    : bus.WR0;
                        bus.HADDR  <= w_pick1 ? bus.ADDR1  : bus.ADDR0;
                        bus.HSIZE  <= w_pick1 ? bus.SIZE1  : bus.SIZE0;
                        bus.HSEL   <= 1'b1;
                        bus.HTRANS <= HTRANS_NONSEQ;
                        r_state    <= ADDR;
                    end
                end

                ADDR: begin
                    bus.HSEL    <= 1'b0;
                    bus.HTRANS  <= HTRANS_IDLE;
                    if (r_wr) begin
                        bus.HWDATA <= r_wdata;
                    end
                    r_wait_left <= CW'(TIMEOUT);
                    r_state     <= DATA;
                end

                DATA: begin
                    if (bus.HREADYOUT) begin
                        if (!r_wr) begin
                            bus.RDATA <= bus.HRDATA;
                        end
                        bus.ERR  <= bus.HRESP;
                        bus.TOUT <= 1'b0;
                        bus.ACK0 <= ~r_win;
                        bus.ACK1 <= r_win;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        bus.ERR  <= 1'b1;
                        bus.TOUT <= 1'b1;
                        bus.ACK0 <= ~r_win;
                        bus.ACK1 <= r_win;
                        r_state  <= DONE;
                    end else if (r_wait_left != '0) begin
                        r_wait_left <= r_wait_left - CW'(1);
                    end
                end

                DONE: begin
                    bus.ACK0   <= 1'b0;
                    bus.ACK1   <= 1'b0;
                    bus.ERR    <= 1'b0;
                    bus.TOUT   <= 1'b0;
                    r_last_gnt <= r_win;
                    r_state    <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_slave_share_arbiter.sv
// Bench for ahb_slave_share_arbiter: a word-wide scratch-RAM slave with programmable
// waits/error/hang, directed scenarios and a randomized phase against a transaction model.
module tb_ahb_slave_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_slave_share_arbiter_if #(.AWIDTH(10)) bus ();

    ahb_slave_share_arbiter #(.AWIDTH(10), .TIMEOUT(16)) dut (
        .i_hclk  (clk),
        .i_hreset(rst),
        .bus     (bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Slave: word RAM, cleared on reset; errored writes are dropped, errored reads still return the word.
    logic [31:0] smem [0:255];
    logic        s_active;
    logic        s_write;
    logic [7:0]  s_idx;
    int          s_k;
    int          cfg_waits = 0;
    bit          cfg_err   = 1'b0;
    bit          cfg_hang  = 1'b0;

    assign bus.HREADYOUT = !s_active ? 1'b1 : cfg_hang ? 1'b0 : cfg_err ? (s_k >= 1) : (s_k >= cfg_waits);
    assign bus.HRESP     = s_active && cfg_err;
    assign bus.HRDATA    = (s_active && !s_write) ? smem[s_idx] : 32'h0BAD_0BAD;

    always @(posedge clk) begin
        if (rst) begin
            s_active <= 1'b0;
            s_k      <= 0;
            for (int i = 0; i < 256; i++) smem[i] <= '0;
        end else if (bus.HSEL && bus.HTRANS == 2'b10) begin
            s_active <= 1'b1;
            s_write  <= bus.HWRITE;
            s_idx    <= bus.HADDR[9:2];
            s_k      <= 0;
        end else if (s_active) begin
            if (bus.HREADYOUT) begin
                s_active <= 1'b0;
                if (s_write && !cfg_err) smem[s_idx] <= bus.HWDATA;
            end else begin
                s_k <= s_k + 1;
            end
        end
    end

    // Bus monitor: address-phase capture, NONSEQ cycle count, dual-ACK detection.
    int          nonseq_cnt   = 0;
    int          both_ack_cnt = 0;
    logic [9:0]  ap_addr;
    logic        ap_write;
    logic [2:0]  ap_size;
    always @(posedge clk) begin
        if (bus.HSEL && bus.HTRANS == 2'b10) begin
            nonseq_cnt <= nonseq_cnt + 1;
            ap_addr    <= bus.HADDR;
            ap_write   <= bus.HWRITE;
            ap_size    <= bus.HSIZE;
        end
        if (bus.ACK0 && bus.ACK1) both_ack_cnt <= both_ack_cnt + 1;
    end

    // Transaction-level reference model.
    logic [31:0] mdl_mem [0:255];
    logic [31:0] mdl_rdata;
    bit          mdl_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input bit on, input bit wr, input logic [9:0] a,
                           input logic [31:0] d, input logic [2:0] s);
        if (idx == 0) begin
            bus.REQ0 = on; bus.WR0 = wr; bus.ADDR0 = a; bus.WDATA0 = d; bus.SIZE0 = s;
        end else begin
            bus.REQ1 = on; bus.WR1 = wr; bus.ADDR1 = a; bus.WDATA1 = d; bus.SIZE1 = s;
        end
    endtask

    task automatic wait_ack(output int lat, output int who);
        lat = 0;
        who = -1;
        while (lat < 60) begin
            tick();
            lat++;
            if (bus.ACK0 || bus.ACK1) begin
                who = bus.ACK1 ? 1 : 0;
                break;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        mdl_rdata = '0;
        mdl_last  = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " ack/err/tout"}, {bus.ACK0, bus.ACK1, bus.ERR, bus.TOUT}, 4'b0000);
        chk({tag, " hsel/hwrite/htrans"}, {bus.HSEL, bus.HWRITE, bus.HTRANS}, 4'b0000);
        chk({tag, " haddr"}, bus.HADDR, 10'h000);
        chk({tag, " hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, " rdata"}, bus.RDATA, 32'h0);
        chk({tag, " hsize"}, bus.HSIZE, 3'b010);
        chk({tag, " consts"}, {bus.HBURST, bus.HMASTLOCK, bus.HPROT}, {3'b000, 1'b0, 4'b0011});
    endtask

    // mode: 0 = normal (waits wait states), 1 = two-cycle error, 2 = slave hangs.
    task automatic xfer(input string tag, input int idx, input bit wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [2:0] s, input int waits, input int mode);
        int lat, who, base_ns, exp_lat;
        cfg_waits = waits;
        cfg_err   = (mode == 1);
        cfg_hang  = (mode == 2);
        exp_lat   = (mode == 2) ? 3 + 16 : (mode == 1) ? 4 : 3 + waits;
        if (!wr && mode != 2) mdl_rdata = mdl_mem[a[9:2]];
        base_ns = nonseq_cnt;
        set_req(idx, 1'b1, wr, a, d, s);
        wait_ack(lat, who);
        set_req(idx, 1'b0, wr, a, d, s);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " ack owner"}, who, idx);
        chk({tag, " single ack"}, {bus.ACK0, bus.ACK1}, (idx == 0) ? 2'b10 : 2'b01);
        chk({tag, " rdata"}, bus.RDATA, mdl_rdata);
        chk({tag, " err/tout"}, {bus.ERR, bus.TOUT}, {mode != 0, mode == 2});
        chk({tag, " nonseq cycles"}, nonseq_cnt - base_ns, 1);
        chk({tag, " addr phase"}, {ap_addr, ap_write, ap_size}, {a, wr, s});
        if (wr && mode == 0) mdl_mem[a[9:2]] = d;
        mdl_last = (idx == 1);
        tick();
        chk({tag, " ack/err clear"}, {bus.ACK0, bus.ACK1, bus.ERR, bus.TOUT}, 4'b0000);
        cfg_hang = 1'b0;
        cfg_err  = 1'b0;
    endtask

    initial begin
        int lat, who, exp_idx;
        logic [31:0] wd0;

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0, 3'd2);
        set_req(1, 1'b0, 1'b0, '0, '0, 3'd2);
        model_reset();
        tick();
        tick();
        chk_reset_values("reset");
        rst = 1'b0;
        tick();

        // Write then read, zero wait states.
        xfer("wr010", 0, 1'b1, 10'h010, 32'hDEADBEEF, 3'd2, 0, 0);
        xfer("rd010", 0, 1'b0, 10'h010, 32'h0, 3'd2, 0, 0);

        // Both requesters held high: grants alternate starting with REQ0.
        xfer("pre104", 1, 1'b1, 10'h104, 32'hCAFE_F00D, 3'd2, 0, 0);
        wd0 = $urandom;
        cfg_waits = 0;
        set_req(0, 1'b1, 1'b1, 10'h100, wd0, 3'd2);
        set_req(1, 1'b1, 1'b0, 10'h104, 32'h0, 3'd2);
        for (int t = 0; t < 8; t++) begin
            exp_idx = mdl_last ? 0 : 1;
            wait_ack(lat, who);
            chk($sformatf("rr%0d owner", t), who, exp_idx);
            chk($sformatf("rr%0d spacing", t), lat, (t == 0) ? 3 : 4);
            if (who == 1) chk($sformatf("rr%0d rdata", t), bus.RDATA, mdl_mem[10'h104 >> 2]);
            mdl_last = (exp_idx == 1);
        end
        set_req(0, 1'b0, 1'b1, 10'h100, wd0, 3'd2);
        set_req(1, 1'b0, 1'b0, 10'h104, 32'h0, 3'd2);
        mdl_mem[10'h100 >> 2] = wd0;
        mdl_rdata = mdl_mem[10'h104 >> 2];
        tick();
        xfer("rd100", 1, 1'b0, 10'h100, 32'h0, 3'd2, 0, 0);

        // Wait states, including exactly the limit.
        xfer("wr020", 1, 1'b1, 10'h020, 32'h12345678, 3'd2, 0, 0);
        xfer("rd020w3", 0, 1'b0, 10'h020, 32'h0, 3'd2, 3, 0);
        xfer("rd020w16", 1, 1'b0, 10'h020, 32'h0, 3'd2, 16, 0);

        // Two-cycle error on a write, then a clean transfer.
        xfer("errwr", 1, 1'b1, 10'h030, 32'h5555_AAAA, 3'd2, 0, 1);
        xfer("rd030", 1, 1'b0, 10'h030, 32'h0, 3'd2, 1, 0);

        // Hung slave: timeout, then REQ1 is accepted.
        xfer("tout", 0, 1'b0, 10'h020, 32'h0, 3'd2, 0, 2);
        xfer("posttout", 1, 1'b0, 10'h020, 32'h0, 3'd2, 0, 0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            int idx, md;
            bit wr;
            logic [9:0] a;
            idx = $urandom_range(0, 1);
            wr  = 1'($urandom_range(0, 1));
            a   = {4'h8, 4'($urandom_range(0, 15)), 2'b00};
            md  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            xfer($sformatf("rnd%0d", t), idx, wr, a, $urandom, 3'($urandom_range(0, 2)),
                 $urandom_range(0, 3), md);
        end

        // Reset during the data phase of a REQ0 read; REQ0 last granted beforehand.
        xfer("prerst", 0, 1'b1, 10'h040, 32'h0F0F_0F0F, 3'd2, 0, 0);
        cfg_hang = 1'b1;
        set_req(0, 1'b1, 1'b0, 10'h020, 32'h0, 3'd2);
        tick();
        tick();
        chk("rst data phase", {bus.HSEL, bus.HTRANS, bus.HADDR}, {1'b0, 2'b00, 10'h020});
        rst = 1'b1;
        set_req(1, 1'b1, 1'b1, 10'h050, 32'h7777_1111, 3'd2);
        tick();
        chk_reset_values("midrst");
        model_reset();
        rst = 1'b0;
        cfg_hang = 1'b0;
        mdl_rdata = mdl_mem[10'h020 >> 2];
        wait_ack(lat, who);
        set_req(0, 1'b0, 1'b0, 10'h020, 32'h0, 3'd2);
        chk("rst reserve owner", who, 0);
        chk("rst reserve latency", lat, 3);
        chk("rst reserve rdata/err", {bus.RDATA, bus.ERR}, {mdl_rdata, 1'b0});
        wait_ack(lat, who);
        set_req(1, 1'b0, 1'b1, 10'h050, 32'h7777_1111, 3'd2);
        chk("rst req1 owner", who, 1);
        chk("rst req1 latency", lat, 4);
        mdl_mem[10'h050 >> 2] = 32'h7777_1111;
        mdl_last = 1'b1;
        tick();
        xfer("rd050", 0, 1'b0, 10'h050, 32'h0, 3'd2, 2, 0);

        chk("no dual ack", both_ack_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
